// File: rtl/step_counter.sv
// Programmable step counter with an inclusive upper limit, up/down direction and wrap/saturate bounds.
// Outputs are registered; tc pulses for one cycle after each boundary event, and ovf latches those events.
module step_counter #(
    parameter int BIT_SZ = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [BIT_SZ-1:0] load_value,
    input  logic [BIT_SZ-1:0] step,
    input  logic [BIT_SZ-1:0] limit,
    input  logic              down,
    input  logic              sat_mode,
    output logic [BIT_SZ-1:0] count,
    output logic              tc,
    output logic              ovf
);

    localparam int XW = BIT_SZ + 1;

    logic [BIT_SZ-1:0] count_q = '0;
    logic              tc_q    = 1'b0;
    logic              ovf_q   = 1'b0;
    logic [BIT_SZ-1:0] count_d;
    logic              tc_d;
    logic              ovf_d;

    logic [XW-1:0] count_x;
    logic [XW-1:0] limit_x;
    logic [XW-1:0] lim1_x;
    logic [XW-1:0] step_x;
    logic [XW-1:0] s_x;
    logic [XW-1:0] raw_up_x;
    logic [XW-1:0] wrap_up_x;
    logic [XW-1:0] wrap_dn_x;
    logic [XW-1:0] diff_dn_x;
    logic [XW-1:0] next_x;
    logic          event_w;

    // One extra bit keeps limit+1 and count+s exact even when limit is all ones.
    assign count_x   = {1'b0, count_q};
    assign limit_x   = {1'b0, limit};
    assign step_x    = {1'b0, step};
    assign lim1_x    = limit_x + XW'(1);
    assign s_x       = (step_x > limit_x) ? limit_x : step_x;
    assign raw_up_x  = count_x + s_x;
    assign wrap_up_x = raw_up_x - lim1_x;
    assign diff_dn_x = count_x - s_x;
    assign wrap_dn_x = (count_x + lim1_x) - s_x;

    always_comb begin
        next_x  = count_x;
        event_w = 1'b0;
        // An out-of-range count (limit lowered mid-run) snaps to a bound before any stepping.
        if (count_x > limit_x) begin
            next_x  = sat_mode ? limit_x : '0;
            event_w = 1'b1;
        end else if (s_x != '0) begin
            if (!down) begin
                if (raw_up_x > limit_x) begin
                    next_x  = sat_mode ? limit_x : wrap_up_x;
                    event_w = 1'b1;
                end else begin
                    next_x = raw_up_x;
                end
            end else begin
                if (count_x < s_x) begin
                    next_x  = sat_mode ? '0 : wrap_dn_x;
                    event_w = 1'b1;
                end else begin
                    next_x = diff_dn_x;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = (load_value > limit) ? limit : load_value;
            ovf_d   = 1'b0;
        end else if (enable) begin
            count_d = next_x[BIT_SZ-1:0];
            tc_d    = event_w;
            ovf_d   = ovf_q | event_w;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter at BIT_SZ=8 with hand-computed expected values.
module tb_step_counter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] step;
    logic [W-1:0] limit;
    logic         down;
    logic         sat_mode;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    step_counter #(.BIT_SZ(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .step       (step),
        .limit      (limit),
        .down       (down),
        .sat_mode   (sat_mode),
        .count      (count),
        .tc         (tc),
        .ovf        (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_chk(input string tag, input int exp_count, input int exp_tc, input int exp_ovf);
        @(posedge clock);
        #1;
        chk({tag, ".count"}, int'(count), exp_count);
        chk({tag, ".tc"},    int'(tc),    exp_tc);
        chk({tag, ".ovf"},   int'(ovf),   exp_ovf);
        $display("step %-10s count=%0d tc=%0d ovf=%0d", tag, count, tc, ovf);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b1; load_value = 8'd50;
        step = 8'd1; limit = 8'd100; down = 1'b0; sat_mode = 1'b0;
        #1;
        chk("powerup.count", int'(count), 0);
        chk("powerup.ovf",   int'(ovf),   0);

        // Reset overrides load and enable
        tick_chk("rst", 0, 0, 0);
        reset = 1'b0; load = 1'b0;

        // Up wrap, limit 9 step 3
        limit = 8'd9; step = 8'd3; enable = 1'b1;
        tick_chk("upw1", 3, 0, 0);
        tick_chk("upw2", 6, 0, 0);
        tick_chk("upw3", 9, 0, 0);
        tick_chk("upw4", 2, 1, 1);
        tick_chk("upw5", 5, 0, 1);
        enable = 1'b0;
        tick_chk("hold", 5, 0, 1);

        // Up saturate, limit 100 step 30
        reset = 1'b1;
        tick_chk("rst2", 0, 0, 0);
        reset = 1'b0;
        limit = 8'd100; step = 8'd30; sat_mode = 1'b1; enable = 1'b1;
        tick_chk("ups1", 30, 0, 0);
        tick_chk("ups2", 60, 0, 0);
        tick_chk("ups3", 90, 0, 0);
        tick_chk("ups4", 100, 1, 1);
        tick_chk("ups5", 100, 1, 1);

        // Down wrap then down saturate, limit 9 step 4 from 5
        limit = 8'd9; step = 8'd4; down = 1'b1; sat_mode = 1'b0;
        load = 1'b1; load_value = 8'd5;
        tick_chk("dwld", 5, 0, 0);
        load = 1'b0;
        tick_chk("dw1", 1, 0, 0);
        tick_chk("dw2", 7, 1, 1);
        sat_mode = 1'b1; load = 1'b1;
        tick_chk("dsld", 5, 0, 0);
        load = 1'b0;
        tick_chk("ds1", 1, 0, 0);
        tick_chk("ds2", 0, 1, 1);
        tick_chk("ds3", 0, 1, 1);

        // Load clamps to limit; oversize step clamps to limit
        down = 1'b0; sat_mode = 1'b0; limit = 8'd150;
        load = 1'b1; load_value = 8'd200;
        tick_chk("ldclamp", 150, 0, 0);
        load = 1'b0; step = 8'd200;
        tick_chk("bigstep", 149, 1, 1);

        // Full range wrap at 255
        limit = 8'd255; step = 8'd1; load = 1'b1; load_value = 8'd255;
        tick_chk("ld255", 255, 0, 0);
        load = 1'b0;
        tick_chk("full", 0, 1, 1);

        // Limit lowered below count
        load = 1'b1; load_value = 8'd200;
        tick_chk("ld200", 200, 0, 0);
        load = 1'b0; limit = 8'd5;
        tick_chk("limdrop", 0, 1, 1);

        // Zero effective step holds with no event
        step = 8'd0; load = 1'b1; load_value = 8'd3;
        tick_chk("ld3", 3, 0, 0);
        load = 1'b0;
        tick_chk("s0", 3, 0, 0);

        // Reset mid-count, resume from 0
        step = 8'd1; reset = 1'b1;
        tick_chk("rstmid", 0, 0, 0);
        reset = 1'b0;
        tick_chk("resume", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter BIT_SZ, default 16, width of count, step, limit and load value.
REQ-002 Port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port enable  input  1  high: advance count by one step this cycle.
REQ-005 Port load  input  1  high: load load_value this cycle.
REQ-006 Port load_value  input  BIT_SZ  value loaded when load=1.
REQ-007 Port step  input  BIT_SZ  increment/decrement magnitude.
REQ-008 Port limit  input  BIT_SZ  inclusive upper bound; legal count range 0..limit.
REQ-009 Port down  input  1  0 = count up, 1 = count down.
REQ-010 Port sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds.
REQ-011 Port count  output  BIT_SZ  registered count value.
REQ-012 Port tc  output  1  registered terminal-count pulse.
REQ-013 Port ovf  output  1  registered sticky flag; set by any boundary event.

Function
REQ-014 Priority per cycle SHALL be reset > load > enable; with none active, all registers hold.
REQ-015 Load SHALL set count = min(load_value, limit), clear ovf, force tc=0 next cycle; enable ignored that cycle.
REQ-016 Effective step SHALL be s = min(step, limit), sampled in the same cycle.
REQ-017 All arithmetic SHALL use BIT_SZ+1 bits internally; limit = 2^BIT_SZ-1 SHALL work with no overflow error.
REQ-018 Up, enabled, count<=limit: raw = count+s; raw<=limit -> count=raw, no boundary event.
REQ-019 Up, raw>limit: wrap mode -> count = raw-(limit+1); sat mode -> count = limit; boundary event.
REQ-020 Down, enabled, count<=limit: count>=s -> count = count-s, no boundary event.
REQ-021 Down, count<s: wrap mode -> count = count+(limit+1)-s; sat mode -> count = 0; boundary event.
REQ-022 Enabled cycle with count>limit (limit lowered mid-run): count SHALL become 0 in wrap mode, limit in sat mode; boundary event.
REQ-023 s=0: count SHALL hold, no boundary event.
REQ-024 Sat mode at limit (up) or 0 (down) with s>0 SHALL produce a boundary event on every enabled cycle.
REQ-025 tc SHALL be 1 for exactly the cycle following each boundary event, else 0; no combinational path from inputs.
REQ-026 ovf SHALL set on any boundary event and stay set until reset or load.
REQ-027 down, sat_mode, step and limit changes SHALL take effect on the next enabled cycle with no extra latency.
REQ-028 Latency from enable sample to updated count SHALL be one clock.

Reset
REQ-029 reset=1 at a rising edge SHALL set count=0, tc=0, ovf=0, overriding load and enable.
REQ-030 Reset asserted mid-count SHALL discard any pending step; counting resumes from 0 on the first enabled cycle after release.
REQ-031 Power-up initial values SHALL equal reset values.

Verification (BIT_SZ=8)
REQ-032 Reset with load=1, enable=1 -> count=0, tc=0, ovf=0.
REQ-033 Up wrap, limit=9, step=3, enable held from 0 -> count 3,6,9,2,5; tc high only the cycle count=2; ovf set then.
REQ-034 Up sat, limit=100, step=30 -> count 30,60,90,100,100; tc high on both 100 cycles.
REQ-035 Down wrap, limit=9, step=4, load 5 then enable -> count 1,7; tc with 7; down sat, same stimulus -> 1,0.
REQ-036 load=1, load_value=200, limit=150, enable=1 -> count=150, tc=0, ovf cleared; step=200 limit=150 up wrap from 150 -> 149.
REQ-037 Full range, limit=255, step=1, count=255, enable -> count=0, tc=1; then limit lowered to 5 at count=200, wrap -> count=0 with tc.
